top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 67 ++++++
 tb/tb_top.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// 4-bit registered add/subtract unit on DE-style board pins.
// KEY[1] is the clock, KEY[0] the asynchronous active-low reset, and KEY[3:2] are ignored.
// SW[9:0] is captured into operand and mode registers on each rising clock edge.
// LEDR is a purely combinational function of those registers.
// The sum is built from a ripple chain of full-adder cells.
// Optional feature: define TOP_SIGNED_OVF_EN to drive the two's-complement overflow flag
// on LEDR[5]. When the macro is undefined, LEDR[5] is tied low.
module top #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  logic clk;
  logic rst_n;
  logic unused_key;

  assign clk        = KEY[1];
  assign rst_n      = KEY[0];
  assign unused_key = ^KEY[3:2];

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             sub_q;

  // Capture operands, carry/borrow-in and mode; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      a_q   <= SW[2*WIDTH-1:WIDTH];
      b_q   <= SW[WIDTH-1:0];
      cin_q <= SW[2*WIDTH];
      sub_q <= SW[2*WIDTH+1];
    end
  end

  // Subtraction is A + ~B + ~borrow_in, so both B and the carry-in flip with the mode bit.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             ovf;

  assign b_eff    = b_q ^ {WIDTH{sub_q}};
  assign carry[0] = cin_q ^ sub_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a_q[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (a_q[i] & b_eff[i]) | (a_q[i] & carry[i]) | (b_eff[i] & carry[i]);
  end

`ifdef TOP_SIGNED_OVF_EN
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf = carry[WIDTH-1] ^ carry[WIDTH];
`else
  assign ovf = 1'b0;
`endif

  assign LEDR = {{(10 - WIDTH - 2){1'b0}}, ovf, carry[WIDTH], sum};

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed spec cases, randomized add/subtract against an
// arithmetic reference model, hold behaviour and asynchronous reset recovery.
`timescale 1ns/1ps
module tb_top;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_hi;
  logic [9:0] sw;
  logic [9:0] ledr;
  logic [3:0] key;

  int n_pass;
  int n_total;

  assign key = {key_hi, clk, rst_n};

  top #(.WIDTH(4)) dut (
    .KEY  (key),
    .SW   (sw),
    .LEDR (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, in the terms of the operation being performed.
  function automatic logic [9:0] model(input int a, input int b, input int cin, input int sub);
    int          r;
    int          sa;
    int          sb;
    int          sr;
    logic        cout;
    logic        ovf;
    logic [3:0]  s;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    if (sub == 0) begin
      r    = a + b + cin;
      cout = (r > 15);
      sr   = sa + sb + cin;
    end else begin
      r    = a - b - cin;
      cout = (a >= b + cin);
      sr   = sa - sb - cin;
    end
    s = 4'((r + 32) % 16);
`ifdef TOP_SIGNED_OVF_EN
    ovf = (sr > 7) || (sr < -8);
`else
    ovf = 1'b0;
`endif
    return {4'b0000, ovf, cout, s};
  endfunction

  function automatic logic [9:0] pack_sw(input int a, input int b, input int cin, input int sub);
    logic [3:0] a4;
    logic [3:0] b4;
    a4 = 4'(a);
    b4 = 4'(b);
    return {1'(sub), 1'(cin), a4, b4};
  endfunction

  // Drive SW at the falling edge, let the next rising edge capture it, sample 1ns later.
  task automatic apply_edge(input logic [9:0] v);
    @(negedge clk);
    sw     = v;
    key_hi = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = 10'h3ff;
    #1;
    n_total++;
    if (ledr !== 10'h000) $display("FAIL reset_async: LEDR=%h required 000", ledr);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (ledr !== 10'h000) $display("FAIL reset_hold_edge%0d: LEDR=%h required 000", i, ledr);
      else n_pass++;
    end
    // Release between edges; the first rising edge must capture normally.
    @(negedge clk);
    rst_n = 1'b1;
    sw    = pack_sw(9, 4, 1, 0);
    @(posedge clk);
    #1;
    n_total++;
    if (ledr !== model(9, 4, 1, 0))
      $display("FAIL reset_first_edge: LEDR=%h required %h", ledr, model(9, 4, 1, 0));
    else n_pass++;
  endtask

  task automatic test_directed();
    int vec[6][4] = '{'{3, 5, 0, 0}, '{15, 1, 0, 0}, '{7, 7, 1, 0},
                      '{5, 3, 0, 1}, '{3, 5, 0, 1}, '{0, 0, 1, 1}};
    logic [9:0] fixed[6];
    logic       ovf_on;
`ifdef TOP_SIGNED_OVF_EN
    ovf_on = 1'b1;
`else
    ovf_on = 1'b0;
`endif
    // Hand-derived results: {ovf, cout, S}.
    fixed[0] = {4'b0, ovf_on, 1'b0, 4'd8};
    fixed[1] = {4'b0, 1'b0,   1'b1, 4'd0};
    fixed[2] = {4'b0, ovf_on, 1'b0, 4'd15};
    fixed[3] = {4'b0, 1'b0,   1'b1, 4'd2};
    fixed[4] = {4'b0, 1'b0,   1'b0, 4'd14};
    fixed[5] = {4'b0, 1'b0,   1'b0, 4'd15};
    for (int i = 0; i < 6; i++) begin
      apply_edge(pack_sw(vec[i][0], vec[i][1], vec[i][2], vec[i][3]));
      n_total++;
      if (ledr !== fixed[i]) $display("FAIL directed%0d: LEDR=%h required %h", i, ledr, fixed[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int a;
    int b;
    int c;
    int m;
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, 1));
      m = int'($urandom_range(0, 1));
      apply_edge(pack_sw(a, b, c, m));
      n_total++;
      if (ledr !== model(a, b, c, m))
        $display("FAIL random%0d a=%0d b=%0d cin=%0d sub=%0d: LEDR=%h required %h",
                 i, a, b, c, m, ledr, model(a, b, c, m));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] v;
    logic [9:0] exp;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      v   = 10'($urandom);
      sw  = v;
      exp = model(int'(v[7:4]), int'(v[3:0]), int'(v[8]), int'(v[9]));
      @(posedge clk);
      #1;
      n_total++;
      if (ledr !== exp) $display("FAIL b2b%0d: LEDR=%h required %h", i, ledr, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_hold_and_recovery();
    logic [9:0] exp;
    apply_edge(pack_sw(6, 9, 0, 1));
    exp = model(6, 9, 0, 1);
    // Change SW without an edge.
    sw = pack_sw(1, 1, 1, 0);
    #2;
    n_total++;
    if (ledr !== exp) $display("FAIL hold: LEDR=%h required %h", ledr, exp);
    else n_pass++;
    @(negedge clk);
    sw = pack_sw(12, 2, 1, 0);
    #1;
    n_total++;
    if (ledr !== exp) $display("FAIL hold_negedge: LEDR=%h required %h", ledr, exp);
    else n_pass++;
    // Reset pulse mid-hold clears immediately.
    rst_n = 1'b0;
    #1;
    n_total++;
    if (ledr !== 10'h000) $display("FAIL reset_midhold: LEDR=%h required 000", ledr);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (ledr !== model(12, 2, 1, 0))
      $display("FAIL recapture: LEDR=%h required %h", ledr, model(12, 2, 1, 0));
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    key_hi  = 2'b00;
    sw      = '0;
    rst_n   = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold_and_recovery();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
